// File: rtl/rx_frame_param.sv
// DDR nibble receiver: assembles bytes, skips a fixed preamble, captures a header
// and streams payload bytes with addresses and per-frame status.
module rx_frame_param #(
  parameter int ADDR_W    = 13,
  parameter int HDR_OFF   = 24,
  parameter int HDR_BYTES = 1
) (
  input  logic                   rxclk,
  input  logic                   rst_n,
  input  logic                   rxctl,
  input  logic [3:0]             rxd,
  output logic [7:0]             dout,
  output logic                   dout_vld,
  output logic [ADDR_W-1:0]      addr,
  output logic [8*HDR_BYTES-1:0] hdr,
  output logic                   hdr_vld,
  output logic [ADDR_W:0]        frame_len,
  output logic                   frame_done,
  output logic                   frame_err
);

  // state | meaning
  // SYNC  | after reset, wait for rxctl = 0 before trusting frame boundaries
  // IDLE  | between frames
  // SKIP  | discarding bytes before the header
  // HDR   | capturing header bytes
  // PAY   | delivering payload bytes
  typedef enum logic [2:0] {SYNC, IDLE, SKIP, HDR, PAY} state_t;

  localparam int PRE = HDR_OFF + HDR_BYTES;
  localparam int PW  = $clog2(PRE + 1);
  localparam logic [PW-1:0]   OFF_C   = PW'(HDR_OFF);
  localparam logic [PW-1:0]   PRE_C   = PW'(PRE);
  localparam logic [PW-1:0]   LASTH_C = PW'(PRE - 1);
  localparam logic [ADDR_W:0] PAY_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t state, state_nxt;

  logic [3:0] rxd_r, rxd_f;
  logic       ctl_r, ctl_f, v1, v2;
  logic [7:0] byte_q;
  logic       dv_q, ber_q;

  logic [PW-1:0]          pre_cnt, pre_nxt, hdr_idx, pre_cnt_d;
  logic [ADDR_W:0]        pay_cnt, pay_inc, pay_cnt_d, len_d;
  logic                   err_acc, err_acc_d, err_base;
  logic [8*HDR_BYTES-1:0] hdr_sh, hdr_sh_d, hdr_d;
  logic [7:0]             dout_d;
  logic [ADDR_W-1:0]      addr_d;
  logic                   dout_vld_d, hdr_vld_d, done_d, err_d;
  logic                   in_pre, is_skip, is_hdr, active, last, hdr_last;
  logic                   pay_ok, ovf, runt, clr;

  always_ff @(negedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_f <= '0;
      ctl_f <= 1'b0;
    end else begin
      rxd_f <= rxd;
      ctl_f <= rxctl;
    end
  end

  // v1/v2 mark pipeline stages holding real samples, so SYNC cannot exit on reset zeros
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_r  <= '0;
      ctl_r  <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      byte_q <= '0;
      dv_q   <= 1'b0;
      ber_q  <= 1'b0;
    end else begin
      rxd_r  <= rxd;
      ctl_r  <= rxctl;
      v1     <= 1'b1;
      v2     <= v1;
      byte_q <= {rxd_f, rxd_r};
      dv_q   <= ctl_r;
      ber_q  <= ctl_r & ~ctl_f;
    end
  end

  // ctl_r already holds the next cycle's DV, so the last byte is known while it is processed
  always_comb begin
    in_pre   = pre_cnt < PRE_C;
    is_skip  = pre_cnt < OFF_C;
    is_hdr   = in_pre && !is_skip;
    active   = (state != SYNC) && dv_q;
    last     = active && !ctl_r;
    hdr_idx  = pre_cnt - OFF_C;
    hdr_last = is_hdr && (pre_cnt == LASTH_C);
    pay_ok   = !in_pre && (pay_cnt != PAY_MAX);
    ovf      = active && !in_pre && (pay_cnt == PAY_MAX);
    runt     = last && in_pre && !hdr_last;
    err_base = (state == IDLE) ? 1'b0 : err_acc;
    pre_nxt  = in_pre ? pre_cnt + 1'b1 : pre_cnt;
    clr      = last || (state == SYNC);
  end

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC: if (v2 && !dv_q) state_nxt = IDLE;
      default: begin
        if (!active || last)    state_nxt = IDLE;
        else if (pre_nxt < OFF_C) state_nxt = SKIP;
        else if (pre_nxt < PRE_C) state_nxt = HDR;
        else                      state_nxt = PAY;
      end
    endcase
  end

  always_comb begin
    hdr_sh_d = hdr_sh;
    for (int i = 0; i < HDR_BYTES; i++)
      if (active && is_hdr && (hdr_idx == PW'(i))) hdr_sh_d[8*i +: 8] = byte_q;
    hdr_d      = hdr;
    hdr_vld_d  = 1'b0;
    if (active && hdr_last) begin
      hdr_d     = hdr_sh_d;
      hdr_vld_d = 1'b1;
    end
    dout_d     = dout;
    addr_d     = addr;
    dout_vld_d = 1'b0;
    if (active && pay_ok) begin
      dout_d     = byte_q;
      addr_d     = pay_cnt[ADDR_W-1:0];
      dout_vld_d = 1'b1;
    end
    pay_inc   = (active && pay_ok) ? pay_cnt + 1'b1 : pay_cnt;
    pay_cnt_d = clr ? '0 : pay_inc;
    pre_cnt_d = clr ? '0 : (active ? pre_nxt : pre_cnt);
    err_acc_d = clr ? 1'b0 : (err_base | (active & ber_q) | ovf);
    done_d    = last;
    err_d     = last && (err_base | ber_q | ovf | runt);
    len_d     = last ? pay_inc : frame_len;
  end

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      pay_cnt    <= '0;
      err_acc    <= 1'b0;
      hdr_sh     <= '0;
      hdr        <= '0;
      hdr_vld    <= 1'b0;
      dout       <= '0;
      addr       <= '0;
      dout_vld   <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pre_cnt    <= pre_cnt_d;
      pay_cnt    <= pay_cnt_d;
      err_acc    <= err_acc_d;
      hdr_sh     <= hdr_sh_d;
      hdr        <= hdr_d;
      hdr_vld    <= hdr_vld_d;
      dout       <= dout_d;
      addr       <= addr_d;
      dout_vld   <= dout_vld_d;
      frame_len  <= len_d;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_rx_frame_param.sv
// Three receivers with different geometries share one DDR stream; each is
// scored against a per-frame model of header, payload and status events.
module tb_rx_frame_param;

  logic       rxclk = 1'b0;
  logic       rst_n;
  logic       rxctl;
  logic [3:0] rxd;

  always #5 rxclk = ~rxclk;

  logic [7:0]  dout0, dout1, dout2;
  logic        vld0, vld1, vld2, hv0, hv1, hv2;
  logic        done0, done1, done2, err0, err1, err2;
  logic [12:0] addr0;
  logic [3:0]  addr1;
  logic [2:0]  addr2;
  logic [7:0]  hdr0, hdr1;
  logic [31:0] hdr2;
  logic [13:0] len0;
  logic [4:0]  len1;
  logic [3:0]  len2;

  rx_frame_param u0 (.rxclk(rxclk), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd),
    .dout(dout0), .dout_vld(vld0), .addr(addr0), .hdr(hdr0), .hdr_vld(hv0),
    .frame_len(len0), .frame_done(done0), .frame_err(err0));

  rx_frame_param #(.ADDR_W(4)) u1 (.rxclk(rxclk), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd),
    .dout(dout1), .dout_vld(vld1), .addr(addr1), .hdr(hdr1), .hdr_vld(hv1),
    .frame_len(len1), .frame_done(done1), .frame_err(err1));

  rx_frame_param #(.ADDR_W(3), .HDR_OFF(0), .HDR_BYTES(4)) u2 (.rxclk(rxclk), .rst_n(rst_n),
    .rxctl(rxctl), .rxd(rxd), .dout(dout2), .dout_vld(vld2), .addr(addr2), .hdr(hdr2),
    .hdr_vld(hv2), .frame_len(len2), .frame_done(done2), .frame_err(err2));

  logic [63:0] o_dout[3], o_addr[3], o_hdr[3], o_len[3];
  logic        o_vld[3], o_hv[3], o_done[3], o_err[3];

  assign o_dout[0] = 64'(dout0); assign o_dout[1] = 64'(dout1); assign o_dout[2] = 64'(dout2);
  assign o_addr[0] = 64'(addr0); assign o_addr[1] = 64'(addr1); assign o_addr[2] = 64'(addr2);
  assign o_hdr[0]  = 64'(hdr0);  assign o_hdr[1]  = 64'(hdr1);  assign o_hdr[2]  = 64'(hdr2);
  assign o_len[0]  = 64'(len0);  assign o_len[1]  = 64'(len1);  assign o_len[2]  = 64'(len2);
  assign o_vld[0]  = vld0;  assign o_vld[1]  = vld1;  assign o_vld[2]  = vld2;
  assign o_hv[0]   = hv0;   assign o_hv[1]   = hv1;   assign o_hv[2]   = hv2;
  assign o_done[0] = done0; assign o_done[1] = done1; assign o_done[2] = done2;
  assign o_err[0]  = err0;  assign o_err[1]  = err1;  assign o_err[2]  = err2;

  int P_A[3]   = '{13, 4, 3};
  int P_OFF[3] = '{24, 24, 0};
  int P_HB[3]  = '{1, 1, 4};

  typedef struct { int addr; int data; bit last; } pay_t;
  typedef struct { int len; bit err; } done_t;

  pay_t        qp[3][$];
  logic [63:0] qh[3][$];
  done_t       qd[3][$];

  logic [7:0] fb[$];
  bit         fe[$];

  int checks = 0;
  int errors = 0;
  int spur   = 0;
  bit mon_en = 1'b0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected events of the frame held in fb/fe, as seen by instance i
  task automatic model(int i);
    int n, pre, npay, cap, del;
    bit err;
    logic [63:0] h;
    pay_t e;
    done_t d;
    n = fb.size();
    pre = P_OFF[i] + P_HB[i];
    err = 1'b0;
    h = '0;
    npay = 0;
    foreach (fe[k]) if (fe[k]) err = 1'b1;
    if (n < pre) err = 1'b1;
    else begin
      for (int j = 0; j < P_HB[i]; j++) h |= 64'(fb[P_OFF[i] + j]) << (8 * j);
      qh[i].push_back(h);
      npay = n - pre;
    end
    cap = 1 << P_A[i];
    del = (npay > cap) ? cap : npay;
    if (npay > cap) err = 1'b1;
    for (int j = 0; j < del; j++) begin
      e.addr = j;
      e.data = int'(fb[pre + j]);
      e.last = (j == npay - 1);
      qp[i].push_back(e);
    end
    d.len = del;
    d.err = err;
    qd[i].push_back(d);
  endtask

  always @(negedge rxclk) begin
    pay_t  e;
    done_t d;
    for (int i = 0; i < 3; i++) begin
      if (!mon_en) begin
        if (o_done[i]) spur++;
      end else begin
        if (o_vld[i]) begin
          if (qp[i].size() == 0) chk($sformatf("u%0d extra dout_vld", i), 64'(1), 64'(0));
          else begin
            e = qp[i].pop_front();
            chk($sformatf("u%0d addr", i), o_addr[i], 64'(e.addr));
            chk($sformatf("u%0d dout", i), o_dout[i], 64'(e.data));
            chk($sformatf("u%0d done_with_byte", i), 64'(o_done[i]), 64'(e.last));
          end
        end
        if (o_hv[i]) begin
          if (qh[i].size() == 0) chk($sformatf("u%0d extra hdr_vld", i), 64'(1), 64'(0));
          else chk($sformatf("u%0d hdr", i), o_hdr[i], qh[i].pop_front());
        end
        if (o_done[i]) begin
          if (qd[i].size() == 0) chk($sformatf("u%0d extra frame_done", i), 64'(1), 64'(0));
          else begin
            d = qd[i].pop_front();
            chk($sformatf("u%0d frame_len", i), o_len[i], 64'(d.len));
            chk($sformatf("u%0d frame_err", i), 64'(o_err[i]), 64'(d.err));
          end
        end else if (o_err[i]) chk($sformatf("u%0d err_without_done", i), 64'(1), 64'(0));
      end
    end
  end

  task automatic drive(bit dv, bit er, logic [7:0] b);
    @(negedge rxclk); #1;
    rxd = b[3:0];
    rxctl = dv;
    @(posedge rxclk); #1;
    rxd = b[7:4];
    rxctl = dv ^ er;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic push(logic [7:0] b, bit e);
    fb.push_back(b);
    fe.push_back(e);
  endtask

  task automatic new_frame();
    fb.delete();
    fe.delete();
  endtask

  task automatic send_frame(int gap);
    for (int i = 0; i < 3; i++) model(i);
    foreach (fb[k]) drive(1'b1, fe[k], fb[k]);
    idle(gap);
  endtask

  task automatic chk_zero(string w);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d dout", w, i), o_dout[i], 64'(0));
      chk($sformatf("%s u%0d dout_vld", w, i), 64'(o_vld[i]), 64'(0));
      chk($sformatf("%s u%0d addr", w, i), o_addr[i], 64'(0));
      chk($sformatf("%s u%0d hdr", w, i), o_hdr[i], 64'(0));
      chk($sformatf("%s u%0d hdr_vld", w, i), 64'(o_hv[i]), 64'(0));
      chk($sformatf("%s u%0d frame_len", w, i), o_len[i], 64'(0));
      chk($sformatf("%s u%0d frame_done", w, i), 64'(o_done[i]), 64'(0));
      chk($sformatf("%s u%0d frame_err", w, i), 64'(o_err[i]), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    rxctl = 1'b0;
    rxd   = 4'h0;
    #12;
    chk_zero("reset");
    #10 rst_n = 1'b1;
    idle(5);
    mon_en = 1'b1;

    new_frame();
    for (int k = 0; k < 24; k++) push(8'($urandom), 1'b0);
    push(8'h5A, 1'b0);
    for (int j = 0; j < 4; j++) push(8'(16 + j), 1'b0);
    send_frame(3);

    new_frame();
    for (int k = 0; k < 20; k++) push(8'($urandom), 1'b0);
    send_frame(2);

    new_frame();
    for (int k = 0; k < 25; k++) push(8'($urandom), 1'b0);
    for (int j = 0; j < 5; j++) push(8'($urandom), j == 2);
    send_frame(2);

    new_frame();
    for (int k = 0; k < 25 + 18; k++) push(8'($urandom), 1'b0);
    send_frame(2);

    new_frame();
    for (int k = 0; k < 25; k++) push(8'($urandom), 1'b0);
    send_frame(2);

    new_frame();
    for (int j = 1; j <= 4; j++) push(8'(j), 1'b0);
    for (int k = 0; k < 6; k++) push(8'($urandom), 1'b0);
    send_frame(1);
    new_frame();
    for (int j = 5; j <= 8; j++) push(8'(j), 1'b0);
    for (int k = 0; k < 3; k++) push(8'($urandom), 1'b0);
    send_frame(6);
    chk("u2 hdr held", o_hdr[2], 64'h08070605);

    mon_en = 1'b0;
    spur = 0;
    new_frame();
    for (int k = 0; k < 25 + 8; k++) push(8'($urandom), 1'b0);
    foreach (fb[k]) begin
      drive(1'b1, 1'b0, fb[k]);
      if (k == 28) begin
        #1 rst_n = 1'b0;
        #1 chk_zero("midframe reset");
        #1 rst_n = 1'b1;
      end
    end
    idle(6);
    chk("no done after reset", 64'(spur), 64'(0));
    mon_en = 1'b1;

    for (int f = 0; f < 40; f++) begin
      new_frame();
      for (int k = 0; k < int'($urandom_range(1, 50)); k++)
        push(8'($urandom), $urandom_range(0, 29) == 0);
      send_frame(int'($urandom_range(1, 3)));
    end

    idle(8);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d payload left", i), 64'(qp[i].size()), 64'(0));
      chk($sformatf("u%0d header left", i), 64'(qh[i].size()), 64'(0));
      chk($sformatf("u%0d done left", i), 64'(qd[i].size()), 64'(0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
